inst_loader: RTL

INST_LOADER -- requirements
Module: inst_loader

---
 rtl/inst_loader.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/inst_loader.sv
// Streams a counted, checksummed sequence of 32-bit words from a byte channel
// into instruction memory, holding the core out of fetch while it loads.
module inst_loader #(
  parameter int unsigned BASE_ADDR  = 0,
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic [7:0]            byte_i,
  input  logic                  byte_valid_i,
  output logic                  byte_ready_o,
  output logic                  we_o,
  output logic [ADDR_WIDTH-1:0] waddr_o,
  output logic [DATA_WIDTH-1:0] wdata_o,
  output logic                  cpu_hold_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_o
);

  localparam logic [ADDR_WIDTH-1:0] BASE_A = ADDR_WIDTH'(BASE_ADDR);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    HDR0  = 3'd1,
    HDR1  = 3'd2,
    DATA  = 3'd3,
    WRITE = 3'd4,
    CHK   = 3'd5,
    DONE  = 3'd6
  } state_t;

  state_t                state_q;
  logic [15:0]           cnt_q;
  logic [15:0]           idx_q;
  logic [1:0]            byte_cnt_q;
  logic [DATA_WIDTH-1:0] word_q;
  logic [7:0]            csum_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  ready_q;
  logic                  we_q;
  logic [ADDR_WIDTH-1:0] waddr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic                  hold_q;
  logic                  busy_q;
  logic                  done_q;
  logic                  err_q;
  logic                  accept_d;

  // ready_q is registered, so the handshake never loops through byte_valid_i
  assign accept_d = byte_valid_i & ready_q;

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q    <= IDLE;
      cnt_q      <= 16'd0;
      idx_q      <= 16'd0;
      byte_cnt_q <= 2'd0;
      word_q     <= '0;
      csum_q     <= 8'd0;
      addr_q     <= '0;
      ready_q    <= 1'b0;
      we_q       <= 1'b0;
      waddr_q    <= '0;
      wdata_q    <= '0;
      hold_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      we_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start_i) begin
            state_q    <= HDR0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            hold_q     <= 1'b1;
            busy_q     <= 1'b1;
            ready_q    <= 1'b1;
            byte_cnt_q <= 2'd0;
            csum_q     <= 8'd0;
            idx_q      <= 16'd0;
            addr_q     <= BASE_A;
          end
        end
        HDR0: begin
          if (accept_d) begin
            cnt_q[7:0] <= byte_i;
            state_q    <= HDR1;
          end
        end
        HDR1: begin
          if (accept_d) begin
            cnt_q[15:8] <= byte_i;
            state_q     <= ({byte_i, cnt_q[7:0]} == 16'd0) ? CHK : DATA;
          end
        end
        DATA: begin
          if (accept_d) begin
            word_q     <= {byte_i, word_q[DATA_WIDTH-1:8]};
            csum_q     <= csum_q ^ byte_i;
            byte_cnt_q <= byte_cnt_q + 2'd1;
            // 4th byte completes the word; present it straight on the write port
            if (byte_cnt_q == 2'd3) begin
              state_q <= WRITE;
              ready_q <= 1'b0;
              we_q    <= 1'b1;
              wdata_q <= {byte_i, word_q[DATA_WIDTH-1:8]};
              waddr_q <= addr_q;
            end
          end
        end
        WRITE: begin
          idx_q   <= idx_q + 16'd1;
          addr_q  <= addr_q + ADDR_WIDTH'(4);
          ready_q <= 1'b1;
          state_q <= (({1'b0, idx_q} + 17'd1) < {1'b0, cnt_q}) ? DATA : CHK;
        end
        CHK: begin
          if (accept_d) begin
            err_q   <= (byte_i != csum_q);
            done_q  <= 1'b1;
            hold_q  <= 1'b0;
            busy_q  <= 1'b0;
            ready_q <= 1'b0;
            state_q <= DONE;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          ready_q <= 1'b0;
          hold_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign byte_ready_o = ready_q;
  assign we_o         = we_q;
  assign waddr_o      = waddr_q;
  assign wdata_o      = wdata_q;
  assign cpu_hold_o   = hold_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign err_o        = err_q;

endmodule
